// File: rtl/svc_rv_dmem_pkg.sv
// Shared types for the wait-state data memory model.
// State encoding and latency counter width.
package svc_rv_dmem_pkg;

  localparam int DMEM_LAT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_wait_state_t;

endpackage

// File: rtl/svc_rv_wstrb_ram.sv
// Byte-enable word array.
// Combinational read port, synchronous strobed write port.
module svc_rv_wstrb_ram #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i
);

  logic [31:0] mem_q [2**AW];

  assign rdata_o = mem_q[raddr_i];

  // Commit enabled byte lanes; contents are never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/svc_rv_dmem_wait.sv
// Data memory with fixed read/write wait states.
// Drives the core's stall and counts stalled cycles.
module svc_rv_dmem_wait
  import svc_rv_dmem_pkg::*;
#(
  parameter int DMEM_AW   = 10,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_ren,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_we,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_stall,
  output logic [31:0] stall_cycles
);

  localparam logic [DMEM_LAT_W-1:0] RL = DMEM_LAT_W'(READ_LAT);
  localparam logic [DMEM_LAT_W-1:0] WL = DMEM_LAT_W'(WRITE_LAT);

  dmem_wait_state_t      state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           sc_q, sc_d;

  logic [DMEM_LAT_W-1:0] rlat, wlat, lat;
  logic                  req, done, ram_we;
  logic [31:0]           ram_rdata;

  logic unused_ok;
  assign unused_ok = ^{dmem_raddr[31:DMEM_AW+2], dmem_raddr[1:0],
                       dmem_waddr[31:DMEM_AW+2], dmem_waddr[1:0]};

  assign req  = dmem_ren | dmem_we;
  assign rlat = dmem_ren ? RL : '0;
  assign wlat = dmem_we ? WL : '0;
  assign lat  = (rlat > wlat) ? rlat : wlat;

  // Next state, stall and completion decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dmem_stall = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (lat == '0) begin
            done = 1'b1;
          end else begin
            dmem_stall = 1'b1;
            state_d    = WAIT;
            cnt_d      = lat - 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          dmem_stall = 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is live on completion, held otherwise.
  always_comb begin
    ram_we     = done & dmem_we;
    dmem_rdata = (done & dmem_ren) ? ram_rdata : rdata_q;
    rdata_d    = dmem_rdata;
    sc_d       = (dmem_stall && sc_q != '1) ? sc_q + 32'd1 : sc_q;
  end

  // FSM, latency counter, read hold and stall statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      sc_q    <= sc_d;
    end
  end

  assign stall_cycles = sc_q;

  svc_rv_wstrb_ram #(
    .AW(DMEM_AW)
  ) u_ram (
    .clk_i  (clock),
    .raddr_i(dmem_raddr[DMEM_AW+1:2]),
    .rdata_o(ram_rdata),
    .we_i   (ram_we),
    .waddr_i(dmem_waddr[DMEM_AW+1:2]),
    .wdata_i(dmem_wdata),
    .wstrb_i(dmem_wstrb)
  );

endmodule

// File: tb/tb_svc_rv_dmem_wait.sv
// Bench for svc_rv_dmem_wait: transaction-level model,
// directed cases plus random traffic on two latency configs.
module tb_svc_rv_dmem_wait;

  logic        clock = 1'b0;
  logic        reset;
  logic        ren, we;
  logic [31:0] raddr, waddr, wdata;
  logic [3:0]  wstrb;

  logic [31:0] a_rdata, a_sc, b_rdata, b_sc;
  logic        a_stall, b_stall;

  always #5 clock = ~clock;

  svc_rv_dmem_wait #(
    .DMEM_AW(10), .READ_LAT(2), .WRITE_LAT(1)
  ) dut_a (
    .clock(clock), .reset(reset),
    .dmem_ren(ren), .dmem_raddr(raddr), .dmem_rdata(a_rdata),
    .dmem_we(we), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_stall(a_stall),
    .stall_cycles(a_sc)
  );

  svc_rv_dmem_wait #(
    .DMEM_AW(10), .READ_LAT(0), .WRITE_LAT(0)
  ) dut_b (
    .clock(clock), .reset(reset),
    .dmem_ren(ren), .dmem_raddr(raddr), .dmem_rdata(b_rdata),
    .dmem_we(we), .dmem_waddr(waddr), .dmem_wdata(wdata),
    .dmem_wstrb(wstrb), .dmem_stall(b_stall),
    .stall_cycles(b_sc)
  );

  int total = 0;
  int bad = 0;

  logic [31:0] mem [1024];
  logic [31:0] m_sc, m_last, last_read;

  bit          chk_en = 1'b0;
  bit          sel_b = 1'b0;
  logic        exp_stall;
  logic [31:0] exp_rd, exp_sc;
  bit          exp_rd_chk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      if (!sel_b) begin
        check("a_stall", {31'd0, a_stall}, {31'd0, exp_stall});
        check("a_sc", a_sc, exp_sc);
        if (exp_rd_chk) check("a_rdata", a_rdata, exp_rd);
      end else begin
        check("b_stall", {31'd0, b_stall}, {31'd0, exp_stall});
        check("b_sc", b_sc, exp_sc);
        if (exp_rd_chk) check("b_rdata", b_rdata, exp_rd);
      end
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  function automatic int lat_of(input bit r, input bit w);
    int rl, wl;
    rl = r ? (sel_b ? 0 : 2) : 0;
    wl = w ? (sel_b ? 0 : 1) : 0;
    return (rl > wl) ? rl : wl;
  endfunction

  // One transaction; requests dropped from cycle drop_at on.
  task automatic txn(input bit r, input logic [31:0] ra,
                     input bit w, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input int drop_at);
    int L;
    logic [31:0] rv;
    L = lat_of(r, w);
    ren = r; raddr = ra; we = w;
    waddr = wa; wdata = wd; wstrb = ws;
    rv = mem[widx(ra)];
    for (int k = 0; k <= L; k++) begin
      if (k == drop_at) begin
        ren = 1'b0;
        we  = 1'b0;
      end
      exp_stall = (k < L);
      exp_sc    = m_sc;
      if (k == L && ren) begin
        exp_rd = rv;
        exp_rd_chk = 1'b1;
      end else begin
        exp_rd = m_last;
        exp_rd_chk = !sel_b;
      end
      chk_en = 1'b1;
      @(posedge clock);
      #1;
      if (k < L && m_sc != 32'hFFFF_FFFF) m_sc++;
    end
    if (ren) begin
      m_last = rv;
      last_read = rv;
    end
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (ws[i]) mem[widx(wa)][8*i +: 8] = wd[8*i +: 8];
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    txn(1'b0, 32'd0, 1'b1, a, d, s, -1);
  endtask

  task automatic rd(input logic [31:0] a);
    txn(1'b1, a, 1'b0, 32'd0, 32'd0, 4'd0, -1);
  endtask

  task automatic rand_phase(input int n);
    logic [31:0] ra, wa;
    int op, drop;
    for (int i = 0; i < 16; i++) begin
      wr(32'h100 + 32'(i * 4), $urandom, 4'hF);
    end
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 3);
      ra = {$urandom_range(0, 255) << 12} | 32'h100 |
           32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      wa = {$urandom_range(0, 255) << 12} | 32'h100 |
           32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      drop = ($urandom_range(0, 7) == 0) ? 1 : -1;
      txn(op[0], ra, op[1], wa, $urandom, 4'($urandom_range(0, 15)),
          drop);
    end
  endtask

  initial begin
    reset = 1'b1;
    ren = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; wstrb = '0;
    m_sc = '0; m_last = '0; last_read = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_stall", {31'd0, a_stall}, 32'd0);
    check("rst_sc", a_sc, 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    reset = 1'b0;

    wr(32'h10, 32'hDEAD_BEEF, 4'hF);
    rd(32'h10);
    check("lit_deadbeef", last_read, 32'hDEAD_BEEF);
    check("lit_sc3", a_sc, 32'd3);

    wr(32'h14, 32'hAABB_CCDD, 4'hF);
    wr(32'h14, 32'h1122_3344, 4'b0101);
    rd(32'h14);
    check("lit_strb", last_read, 32'hAA22_CC44);

    wr(32'h20, 32'h1, 4'hF);
    txn(1'b1, 32'h20, 1'b1, 32'h20, 32'h2, 4'hF, -1);
    check("lit_rbw_old", last_read, 32'h1);
    rd(32'h20);
    check("lit_rbw_new", last_read, 32'h2);

    wr(32'h1000, 32'hCAFE_F00D, 4'hF);
    rd(32'h0);
    check("lit_alias", last_read, 32'hCAFE_F00D);

    wr(32'h24, 32'h55, 4'hF);
    wr(32'h24, 32'h77, 4'h0);
    txn(1'b1, 32'h24, 1'b1, 32'h24, 32'h66, 4'hF, 1);
    rd(32'h24);
    check("lit_drop", last_read, 32'h55);

    wr(32'h28, 32'h77, 4'hF);
    chk_en = 1'b0;
    ren = 1'b1; we = 1'b1;
    raddr = 32'h28; waddr = 32'h28;
    wdata = 32'h99; wstrb = 4'hF;
    @(posedge clock);
    #1;
    check("wait_stall", {31'd0, a_stall}, 32'd1);
    reset = 1'b1;
    ren = 1'b0; we = 1'b0;
    #1;
    check("arst_stall", {31'd0, a_stall}, 32'd0);
    check("arst_sc", a_sc, 32'd0);
    check("arst_rdata", a_rdata, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_sc = '0; m_last = '0;
    rd(32'h28);
    check("lit_arst_keep", last_read, 32'h77);

    rand_phase(60);

    sel_b = 1'b1;
    m_sc = '0;
    rand_phase(100);

    chk_en = 1'b0;
    ren = 1'b0; we = 1'b0;
    @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
